imem_responder: RTL and testbench

Instruction-memory responder: the SRAM-side end of the fetch interface.
- Accepts fetch requests (PC address + valid) from the instruction fetch unit.
- Returns the addressed 32-bit instruction with a valid strobe after a fixed, parameterised latency. Fully pipelined, in order.
- A side write port preloads program contents; a flush input kills in-flight responses on redirect.

---
 rtl/imem_responder_pkg.sv | 8 +
 rtl/imem_lat_pipe.sv | 50 +++++
 rtl/imem_responder.sv | 77 +++++++
 tb/tb_imem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared constants for the instruction-memory responder: the NOP encoding
// returned on idle cycles and on faulted fetches.
package imem_responder_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] IMEM_ERR_NOP = NOP_INSTR;

endpackage

// File: rtl/imem_lat_pipe.sv
// Fixed-latency valid/data/err shift pipeline. Stage 0 captures the fetch
// result at acceptance; flush kills older entries but never the incoming one.
module imem_lat_pipe
    import imem_responder_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_vld,
    input  logic [31:0] in_data,
    input  logic        in_err,
    output logic        out_vld,
    output logic [31:0] out_data,
    output logic        out_err
);

    logic        vld_p  [LATENCY];
    logic [31:0] data_p [LATENCY];
    logic        err_p  [LATENCY];

    // stage 0 takes the new request; later stages shift, killed by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= in_vld;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1] && !flush_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        data_p[0] <= in_data;
        err_p[0]  <= in_err;
        for (int i = 1; i < LATENCY; i++) begin
            data_p[i] <= data_p[i-1];
            err_p[i]  <= err_p[i-1];
        end
    end

    assign out_vld  = vld_p[LATENCY-1];
    assign out_data = data_p[LATENCY-1];
    assign out_err  = err_p[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// SRAM-side end of the fetch interface: word array with a preload write port,
// address decode with fault detection, and a fixed-latency response pipeline.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    input  logic [31:0]   req_addr_i,
    output logic          req_ready_o,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i,
    output logic          instr_valid_o,
    output logic [31:0]   instr_o,
    output logic          instr_err_o
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("imem_responder: LATENCY must be in 1..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("imem_responder: DEPTH must be a power of two >= 2");
    end

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_idx;
    logic [31:0]   addr_hi;
    logic          misaligned;
    logic          out_of_range;
    logic          rd_err;
    logic [31:0]   rd_data;
    logic          pipe_vld;
    logic [31:0]   pipe_data;
    logic          pipe_err;

    // Write and pipeline capture share the edge, so a same-index read sees old data.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_idx       = req_addr_i[AW+1:2];
    assign addr_hi      = req_addr_i >> (AW + 2);
    assign misaligned   = |req_addr_i[1:0];
    assign out_of_range = |addr_hi;
    assign rd_err       = misaligned || out_of_range;
    assign rd_data      = rd_err ? IMEM_ERR_NOP : mem[rd_idx];

    assign req_ready_o  = rst_n;

    imem_lat_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush_i),
        .in_vld   (req_valid_i),
        .in_data  (rd_data),
        .in_err   (rd_err),
        .out_vld  (pipe_vld),
        .out_data (pipe_data),
        .out_err  (pipe_err)
    );

    // idle cycles present a clean NOP regardless of stale pipeline data
    assign instr_valid_o = pipe_vld;
    assign instr_o       = pipe_vld ? pipe_data : NOP_INSTR;
    assign instr_err_o   = pipe_vld && pipe_err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: three responders (LATENCY 1, 2, 3) share one stimulus stream.
module tb_imem_responder;

    localparam int AW = 10;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          flush;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    logic        rdy1, rdy2, rdy3;
    logic        v1, v2, v3;
    logic [31:0] d1, d2, d3;
    logic        e1, e2, e3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_ready_o(rdy1), .flush_i(flush), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .instr_valid_o(v1), .instr_o(d1), .instr_err_o(e1));

    imem_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_ready_o(rdy2), .flush_i(flush), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .instr_valid_o(v2), .instr_o(d2), .instr_err_o(e2));

    imem_responder #(.DEPTH(1024), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_ready_o(rdy3), .flush_i(flush), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .instr_valid_o(v3), .instr_o(d3), .instr_err_o(e3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        req_valid = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        logic [31:0] words [4];
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        words[3] = 32'h4444_4444;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        tick();
        tick();

        // reset state
        chk("rst_valid_l1", {31'd0, v1}, 32'd0);
        chk("rst_instr_l1", d1, NOP);
        chk("rst_err_l3",   {31'd0, e3}, 32'd0);
        chk("rst_ready",    {31'd0, rdy2}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", {31'd0, rdy1}, 32'd1);

        // preload mem[0..3]
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = words[i];
            tick();
        end
        wr_en = 1'b0;

        // back-to-back fetches at LATENCY 1
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * k);
            tick();
            chk("b2b_valid", {31'd0, v1}, 32'd1);
            chk("b2b_instr", d1, words[k]);
            chk("b2b_err",   {31'd0, e1}, 32'd0);
        end
        req_valid = 1'b0;
        tick();
        chk("b2b_idle_valid", {31'd0, v1}, 32'd0);
        chk("b2b_idle_instr", d1, NOP);
        drain();

        // single fetch of addr 0x8: each instance responds once, LATENCY cycles later
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        req_valid = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            chk("lat_v1", {31'd0, v1}, (d == 1) ? 32'd1 : 32'd0);
            chk("lat_v2", {31'd0, v2}, (d == 2) ? 32'd1 : 32'd0);
            chk("lat_v3", {31'd0, v3}, (d == 3) ? 32'd1 : 32'd0);
            chk("lat_d3", d3, (d == 3) ? 32'h3333_3333 : NOP);
            tick();
        end
        drain();

        // misaligned then out-of-range
        req_valid = 1'b1;
        req_addr  = 32'h6;
        tick();
        chk("misal_valid", {31'd0, v1}, 32'd1);
        chk("misal_instr", d1, NOP);
        chk("misal_err",   {31'd0, e1}, 32'd1);
        req_addr = 32'h1000;
        tick();
        req_valid = 1'b0;
        chk("oor_valid", {31'd0, v1}, 32'd1);
        chk("oor_instr", d1, NOP);
        chk("oor_err",   {31'd0, e1}, 32'd1);
        chk("misal_err_l2", {31'd0, e2}, 32'd1);
        tick();
        chk("oor_err_l2", {31'd0, e2}, 32'd1);
        chk("oor_idle_err_l1", {31'd0, e1}, 32'd0);
        drain();

        // read-before-write on the same index
        wr_en     = 1'b1;
        wr_addr   = AW'(2);
        wr_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        wr_en = 1'b0;
        chk("rbw_old", d1, 32'h3333_3333);
        tick();
        req_valid = 1'b0;
        chk("rbw_new", d1, 32'hDEAD_BEEF);
        chk("rbw_new_valid", {31'd0, v1}, 32'd1);
        drain();

        // flush with three requests in flight; only the flush-cycle request survives
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_addr = 32'hC;
        flush    = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_c3_v3", {31'd0, v3}, 32'd0);
        chk("flush_c3_v2", {31'd0, v2}, 32'd0);
        chk("flush_c3_d1", d1, 32'h4444_4444);
        tick();
        chk("flush_c4_v3", {31'd0, v3}, 32'd0);
        chk("flush_c4_d2", d2, 32'h4444_4444);
        tick();
        chk("flush_c5_v3", {31'd0, v3}, 32'd1);
        chk("flush_c5_d3", d3, 32'h4444_4444);
        tick();
        chk("flush_c6_v3", {31'd0, v3}, 32'd0);
        drain();

        // asynchronous reset mid-stream
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_v2", {31'd0, v2}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_v2", {31'd0, v2}, 32'd0);
        chk("async_rst_d2", d2, NOP);
        chk("async_rst_v1", {31'd0, v1}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_v2", {31'd0, v2}, 32'd0);
            chk("post_rst_v3", {31'd0, v3}, 32'd0);
        end
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_valid = 1'b0;
        chk("retain_d1", d1, 32'h1111_1111);
        tick();
        chk("retain_d2", d2, 32'h1111_1111);
        chk("retain_v2", {31'd0, v2}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
